// File: rtl/led_scan_ctrl_if.sv
// Bundle between the LED scan controller and its neighbours: the renderer
// handshake, the framebuffer read port and the panel pins.
//   master (scan controller): drives swap_ack, frame_start, fb_sel, fb_addr,
//     r_top, r_bot, sclk, lat, oe_n, row_addr; reads enable, frame_ready, fb_data.
//   slave (renderer/framebuffer/panel side): the mirror image.
interface led_scan_ctrl_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned ROW_W  = 5;

    logic              enable;
    logic              frame_ready;
    logic              swap_ack;
    logic              frame_start;
    logic              fb_sel;
    logic [ADDR_W-1:0] fb_addr;
    logic [1:0]        fb_data;
    logic              r_top;
    logic              r_bot;
    logic              sclk;
    logic              lat;
    logic              oe_n;
    logic [ROW_W-1:0]  row_addr;

    modport master (
        input  enable, frame_ready, fb_data,
        output swap_ack, frame_start, fb_sel, fb_addr,
               r_top, r_bot, sclk, lat, oe_n, row_addr
    );

    modport slave (
        output enable, frame_ready, fb_data,
        input  swap_ack, frame_start, fb_sel, fb_addr,
               r_top, r_bot, sclk, lat, oe_n, row_addr
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// 1/32-scan controller for a 64x64 single-colour LED panel. Each pass reads
// rows r and r+32 from the front framebuffer, shifts 64 columns out, latches
// them and enables the display for DISP_CYCLES clocks. The front/back buffer
// swap is only taken at frame end, so a frame never tears.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         led_scan_ctrl_if.master (handshake, framebuffer port, panel pins)
module led_scan_ctrl #(
    parameter int unsigned DISP_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    led_scan_ctrl_if.master bus
);
    localparam int unsigned CNT_W        = 12;
    localparam int unsigned ROW_W        = 5;
    localparam int unsigned COL_W        = 6;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned SHIFT_CYCLES = 128;
    localparam int unsigned LAST_ROW     = 31;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                swap_q, swap_d;
    logic                fs_q, fs_d;
    logic                sclk_q, sclk_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic [ROW_W-1:0]    row_addr_q, row_addr_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [COL_W-1:0]    col_d;
    logic                top_hold_q, bot_hold_q;
    logic                shift_last, disp_last;

    assign shift_last = (cnt_q == CNT_W'(SHIFT_CYCLES - 1));
    assign disp_last  = (cnt_q == CNT_W'(DISP_CYCLES - 1));

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        swap_d     = 1'b0;
        fs_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = PREFETCH;
                    row_d   = '0;
                    cnt_d   = '0;
                    fs_d    = 1'b1;
                end
            end
            PREFETCH: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                if (shift_last) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLANK: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d = DISPLAY;
                cnt_d   = '0;
            end
            DISPLAY: begin
                if (disp_last) begin
                    cnt_d = '0;
                    if (row_q != ROW_W'(LAST_ROW)) begin
                        state_d = PREFETCH;
                        row_d   = row_q + ROW_W'(1);
                    end else begin
                        // Frame end: the only point where buffers swap or scanning stops.
                        row_d = '0;
                        if (bus.frame_ready) begin
                            sel_d  = ~sel_q;
                            swap_d = 1'b1;
                        end
                        if (bus.enable) begin
                            state_d = PREFETCH;
                            fs_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address one column ahead on the sclk-high cycle so data lands on the next column's first cycle.
        col_d  = cnt_d[6:1] + COL_W'(cnt_d[0]);
        sclk_d = (state_d == SHIFT) && cnt_d[0];
        lat_d  = (state_d == LATCH);
        oe_n_d = (state_d != DISPLAY);

        row_addr_d = row_addr_q;
        if (state_d == BLANK) begin
            row_addr_d = row_d;
        end else if (state_d == IDLE) begin
            row_addr_d = '0;
        end

        fb_addr_d = fb_addr_q;
        case (state_d)
            IDLE:     fb_addr_d = '0;
            PREFETCH: fb_addr_d = {sel_d, row_d, COL_W'(0)};
            SHIFT:    fb_addr_d = {sel_d, row_d, col_d};
            default:  fb_addr_d = fb_addr_q;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            swap_q     <= 1'b0;
            fs_q       <= 1'b0;
            sclk_q     <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            row_addr_q <= '0;
            fb_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            swap_q     <= swap_d;
            fs_q       <= fs_d;
            sclk_q     <= sclk_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
            row_addr_q <= row_addr_d;
            fb_addr_q  <= fb_addr_d;
        end
    end

    // Read data arrives on a column's first cycle; hold it for the sclk-high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_hold_q <= 1'b0;
            bot_hold_q <= 1'b0;
        end else if ((state_q == SHIFT) && !cnt_q[0]) begin
            top_hold_q <= bus.fb_data[0];
            bot_hold_q <= bus.fb_data[1];
        end
    end

    // Pixel pins pass the read data through on the first cycle of a column
    // (one-cycle RAM latency leaves no slot to register it) and are 0 outside SHIFT.
    assign bus.r_top = (state_q == SHIFT) && (cnt_q[0] ? top_hold_q : bus.fb_data[0]);
    assign bus.r_bot = (state_q == SHIFT) && (cnt_q[0] ? bot_hold_q : bus.fb_data[1]);

    assign bus.swap_ack    = swap_q;
    assign bus.frame_start = fs_q;
    assign bus.fb_sel      = sel_q;
    assign bus.fb_addr     = fb_addr_q;
    assign bus.sclk        = sclk_q;
    assign bus.lat         = lat_q;
    assign bus.oe_n        = oe_n_q;
    assign bus.row_addr    = row_addr_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl (DISP_CYCLES=4). The stimulus process
// predicts every row pass from a pixel array and the frame-level buffer rules,
// pushing one record per row; the monitor rebuilds each pass from the panel
// pins and pops/compares on every latch pulse.
module tb_led_scan_ctrl;
    localparam int DISP    = 4;
    localparam int ROW_PER = 131 + DISP;
    localparam int FRM_PER = 32 * ROW_PER;
    localparam logic [24:0] RST_OUTS = 25'(1) << 20;

    typedef struct {
        int          row;
        bit          sel;
        bit          swap;
        bit          chk_period;
        logic [63:0] top;
        logic [63:0] bot;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    led_scan_ctrl_if bus();

    led_scan_ctrl #(.DISP_CYCLES(DISP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Framebuffer: pixel array is the reference, mem is its packed RAM image.
    bit         pix [2][64][64];
    logic [1:0] mem [0:4095];

    always @(posedge clk) bus.fb_data <= mem[bus.fb_addr];

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t exp_q[$];

    bit m_sel, m_swap, m_chk;
    int m_frames = 0;
    int m_swaps  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] outs();
        return {bus.sclk, bus.lat, bus.r_top, bus.r_bot, bus.oe_n, bus.row_addr,
                bus.fb_addr, bus.fb_sel, bus.swap_ack, bus.frame_start};
    endfunction

    task automatic push_frame();
        for (int r = 0; r < 32; r++) begin
            rec_t e;
            e.row        = r;
            e.sel        = m_sel;
            e.swap       = (r == 0) ? m_swap : 1'b0;
            e.chk_period = (r == 0) && m_chk;
            for (int c = 0; c < 64; c++) begin
                e.top[c] = pix[m_sel][r][c];
                e.bot[c] = pix[m_sel][r+32][c];
            end
            exp_q.push_back(e);
        end
        m_frames++;
        m_chk = 1'b1;
    endtask

    task automatic frame_end(input bit fr);
        if (fr) begin
            m_sel = ~m_sel;
            m_swaps++;
        end
        m_swap = fr;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_start;
        end
        check("frame_start_seen", seen, 1);
    endtask

    task automatic fs_check();
        check("fs_fb_sel", bus.fb_sel, m_sel);
        check("fs_fb_addr", bus.fb_addr, longint'({m_sel, 11'd0}));
    endtask

    // Monitor state
    int          cyc = 0;
    int          fs_count = 0, swap_count = 0, proto_err = 0;
    int          n_edge = 0, disp_cnt = 0;
    int          last_fs = 0, last_period = 0;
    bit          have_fs = 1'b0, fs_swap = 1'b0, in_disp = 1'b0;
    bit          msb0 = 1'b0, msb_bad = 1'b0;
    logic        sclk_p = 1'b0, lat_p = 1'b0, oe_p = 1'b1, top_p = 1'b0, bot_p = 1'b0;
    logic [63:0] top_bits, bot_bits;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            n_edge  = 0;
            disp_cnt = 0;
            in_disp = 1'b0;
            msb_bad = 1'b0;
            sclk_p  = 1'b0;
            lat_p   = 1'b0;
            oe_p    = 1'b1;
            top_p   = 1'b0;
            bot_p   = 1'b0;
        end else begin
            if (bus.frame_start) begin
                fs_count++;
                if (have_fs) last_period = cyc - last_fs;
                last_fs = cyc;
                have_fs = 1'b1;
                fs_swap = bus.swap_ack;
            end
            if (bus.swap_ack) swap_count++;

            if (bus.sclk && sclk_p) proto_err++;
            if (bus.sclk && !sclk_p) begin
                if (bus.r_top !== top_p || bus.r_bot !== bot_p) proto_err++;
                if (n_edge < 64) begin
                    top_bits[n_edge] = bus.r_top;
                    bot_bits[n_edge] = bus.r_bot;
                end
                if (n_edge == 0) msb0 = bus.fb_addr[11];
                else if (bus.fb_addr[11] !== msb0) msb_bad = 1'b1;
                n_edge++;
            end
            if (bus.lat && (bus.sclk || !bus.oe_n || lat_p || sclk_p || bus.r_top || bus.r_bot))
                proto_err++;
            if (!bus.oe_n && (bus.sclk || bus.r_top || bus.r_bot)) proto_err++;
            if (lat_p && bus.oe_n) proto_err++;

            if (!bus.oe_n) begin
                disp_cnt++;
                in_disp = 1'b1;
            end
            if (bus.oe_n && !oe_p && in_disp) begin
                check("disp_cycles", disp_cnt, DISP);
                disp_cnt = 0;
                in_disp  = 1'b0;
            end

            if (bus.lat) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL row_unexpected: latch with no expected row, row_addr=%0d", bus.row_addr);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    check("row_addr", bus.row_addr, e.row);
                    check("row_fb_sel", bus.fb_sel, e.sel);
                    check("row_top_bits", top_bits, e.top);
                    check("row_bot_bits", bot_bits, e.bot);
                    check("row_sclk_edges", n_edge, 64);
                    check("row_addr_msb", msb_bad ? 2 : msb0, e.sel);
                    check("row_protocol", proto_err, 0);
                    if (e.row == 0) begin
                        check("fs_swap_ack", fs_swap, e.swap);
                        if (e.chk_period) check("frame_period", last_period, FRM_PER);
                    end
                end
                n_edge  = 0;
                msb_bad = 1'b0;
            end
            sclk_p = bus.sclk;
            lat_p  = bus.lat;
            oe_p   = bus.oe_n;
            top_p  = bus.r_top;
            bot_p  = bus.r_bot;
        end
    end

    initial begin
        int bad;
        rst_n           = 1'b0;
        bus.enable      = 1'b0;
        bus.frame_ready = 1'b0;
        m_sel  = 1'b0;
        m_swap = 1'b0;
        m_chk  = 1'b0;

        // Buffer 0 sparse (two marker pixels), buffer 1 random.
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                pix[0][r][c] = 1'b0;
                pix[1][r][c] = 1'($urandom);
            end
        pix[0][3][10]  = 1'b1;
        pix[0][35][63] = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 64; c++)
                    mem[b*2048 + r*64 + c] = {pix[b][r+32][c], pix[b][r][c]};

        wait_cycles(3);
        check("rst_outputs", outs(), RST_OUTS);
        rst_n = 1'b1;
        wait_cycles(5);
        check("idle_oe_n", bus.oe_n, 1);
        check("idle_no_fs", fs_count, 0);

        // Frame 0 (buffer 0); frame_ready rises mid-frame and stays high across two frame ends.
        push_frame();
        bus.enable = 1'b1;
        wait_fs(10);
        fs_check();
        wait_cycles(16 * ROW_PER);
        bus.frame_ready = 1'b1;
        frame_end(1);
        push_frame();
        wait_fs(FRM_PER + 50);          // frame 1, buffer 1
        fs_check();
        frame_end(1);
        push_frame();
        wait_fs(FRM_PER + 50);          // frame 2, buffer 0
        fs_check();
        bus.frame_ready = 1'b0;
        wait_cycles(16 * ROW_PER);
        bus.frame_ready = 1'b1;
        frame_end(1);
        push_frame();
        wait_fs(FRM_PER + 50);          // frame 3, buffer 1; renderer drops on swap_ack
        fs_check();
        bus.frame_ready = 1'b0;
        frame_end(0);
        push_frame();
        wait_fs(FRM_PER + 50);          // frame 4
        fs_check();
        frame_end(0);
        push_frame();
        wait_fs(FRM_PER + 50);          // frame 5; enable dropped at row 10
        fs_check();
        wait_cycles(10 * ROW_PER + 50);
        bus.enable = 1'b0;
        frame_end(0);
        wait_cycles(FRM_PER - 10 * ROW_PER);

        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.oe_n !== 1'b1 || bus.sclk !== 1'b0 || bus.lat !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_fs_count", fs_count, m_frames);
        check("idle_swap_count", swap_count, m_swaps);
        check("idle_queue_drained", exp_q.size(), 0);

        // Re-enable: restarts at row 0 on the same buffer.
        m_chk = 1'b0;
        push_frame();
        bus.enable = 1'b1;
        wait_fs(10);
        fs_check();

        // Reset during DISPLAY of row 7.
        wait_cycles(7 * ROW_PER + 132);
        check("pre_rst_oe_n", bus.oe_n, 0);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_outputs", outs(), RST_OUTS);
        exp_q.delete();
        wait_cycles(2);
        m_sel  = 1'b0;
        m_swap = 1'b0;
        m_chk  = 1'b0;
        push_frame();
        rst_n = 1'b1;
        wait_fs(10);
        fs_check();
        wait_cycles(20 * ROW_PER);
        bus.enable = 1'b0;
        wait_cycles(FRM_PER - 20 * ROW_PER + 100);

        check("end_queue_drained", exp_q.size(), 0);
        check("end_fs_count", fs_count, m_frames);
        check("end_swap_count", swap_count, m_swaps);
        check("end_protocol", proto_err, 0);
        check("end_oe_n", bus.oe_n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

- Scan controller for the 64x64 single-colour Pong LED panel, driven 1/32-scan: two rows, r and r+32, are shifted per pass.
- Sequences reads from the double-buffered pixel framebuffer, shifts column data to the panel, latches it, and gates the display-enable time per row.
- Owns buffer swapping with the renderer through a frame_ready/swap_ack handshake, so a frame never tears mid-scan.
- Sits between the framebuffer RAM (written by the game/render logic) and the panel pins.

## Interface
- DISP_CYCLES, 256, clocks oe_n is held low per row; legal range 1..4095.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning allowed; sampled only in IDLE and at frame end.
- frame_ready  in  1  level from renderer: back buffer complete.
- swap_ack  out  1  one-cycle pulse: fb_sel toggled, back buffer released.
- frame_start  out  1  one-cycle pulse at the first cycle of row 0.
- fb_sel  out  1  buffer currently scanned (front buffer).
- fb_addr  out  12  framebuffer read address, {fb_sel, row[4:0], col[5:0]}.
- fb_data  in  2  {pixel(row+32,col), pixel(row,col)}; valid the cycle after fb_addr.
- r_top  out  1  panel data, upper half.
- r_bot  out  1  panel data, lower half.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe_n  out  1  panel output enable, active low.
- row_addr  out  5  panel row select A..E.

## Operation
- States: IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: outputs at reset values. With enable=1, go to PREFETCH for row 0 and pulse frame_start.
- PREFETCH (1 cycle): fb_addr = {fb_sel, row, 0}.
- SHIFT (128 cycles): column c = 0..63 occupies 2 cycles.
  - Cycle 0: sclk=0. Cycle 1: sclk=1.
  - r_top/r_bot hold pixel(row,c)/pixel(row+32,c) for both cycles.
  - fb_addr advances so each column's data is ready in its first cycle.
- BLANK (1 cycle): oe_n=1, sclk=0; row_addr updates to the row just shifted.
- LATCH (1 cycle): lat=1.
- DISPLAY (DISP_CYCLES cycles): oe_n=0, lat=0.
  - Exit when row < 31: row+1, go to PREFETCH.
  - Exit when row = 31: frame end (below).
- oe_n is 1 in every state except DISPLAY.
- Frame end, at the last DISPLAY cycle of row 31, sampled there:
  - frame_ready=1: fb_sel toggles and swap_ack pulses high for 1 cycle in the following cycle.
  - enable=1: row wraps to 0, go to PREFETCH, and frame_start pulses in that PREFETCH cycle (same cycle as any swap_ack).
  - enable=0: go to IDLE.
- frame_ready=0 at frame end: no swap; the same buffer is rescanned.
- Renderer must drop frame_ready within 1 cycle of swap_ack; frame_ready still high at the next frame end causes another swap.
- enable dropped mid-frame: the current frame completes, then IDLE.
- r_top, r_bot and sclk are 0 outside SHIFT.

## Timing
- Row period = 1 + 128 + 1 + 1 + DISP_CYCLES = 131 + DISP_CYCLES clocks.
- Frame period = 32 × row period.
- Panel data changes only on sclk's falling edge (first cycle of a column). It is stable for 1 cycle before the sclk rising edge and throughout sclk high.
- lat is never high while sclk=1 or oe_n=0.
- Framebuffer read latency is exactly 1 cycle; no stall input exists.
- The fb_sel in force at PREFETCH of row 0 is used for the whole frame.
- Reset values: state IDLE; sclk, lat, r_top, r_bot = 0; oe_n = 1; row_addr, fb_addr, fb_sel = 0; swap_ack, frame_start = 0.
- Reset asserted mid-row takes effect immediately (asynchronous): oe_n goes high with no glitch low. After release, scanning restarts at row 0 with fb_sel=0.

## Test plan
- Reset then enable=1, DISP_CYCLES=4 -> frame_start pulses every 32×135 = 4320 cycles; row_addr steps 0..31 then wraps to 0.
- Framebuffer with pixel(3,10)=1 and pixel(35,63)=1 -> in row 3:
  - r_top=1 only during column 10's 2 cycles.
  - r_bot=1 only during column 63.
  - exactly 64 sclk rising edges, then lat=1 for 1 cycle, then oe_n=0 for 4 cycles.
- frame_ready=1 held from mid-frame 0 -> fb_sel goes 0→1 and swap_ack pulses once, coincident with frame 1's frame_start. The frame 1 fb_addr MSB is 1.
- frame_ready held high across two frame ends -> two swaps (fb_sel back to 0). frame_ready=0 -> fb_sel unchanged over 3 frames.
- enable dropped at row 10 -> rows 10..31 complete, then IDLE with oe_n=1 and no further sclk edges. Re-enable -> restarts at row 0.
- rst_n pulsed low during DISPLAY of row 7 -> oe_n=1 in the same cycle and all outputs at reset values. After release with enable=1 -> PREFETCH of row 0 with fb_sel=0.
